// File: rtl/vga_scene_renderer_if.sv
// Signal bundle between the game/timing logic and the scene renderer.
// The master drives scan position and object state; the slave returns pixel colour.
interface vga_scene_renderer_if #(
  parameter int unsigned NUM_OBS = 4,
  parameter int unsigned COLOR_W = 8
);
  logic [9:0]           x;
  logic [9:0]           y;
  logic                 active_pixels;
  logic [1:0]           game_state;
  logic                 menu_selection;
  logic [9:0]           player_x;
  logic [9:0]           player_height;
  logic [10*NUM_OBS-1:0] obs_x;
  logic [10*NUM_OBS-1:0] obs_y;
  logic [10*NUM_OBS-1:0] obs_w;
  logic [10*NUM_OBS-1:0] obs_h;
  logic [NUM_OBS-1:0]   obs_valid;
  logic                 hit_pulse;
  logic                 t_start;
  logic                 t_howto;
  logic                 t_hud;
  logic                 i_white;
  logic                 i_green;
  logic                 i_red;
  logic [COLOR_W-1:0]   VGA_R;
  logic [COLOR_W-1:0]   VGA_G;
  logic [COLOR_W-1:0]   VGA_B;
  logic                 active_out;
  logic                 collision;

  modport master (
    output x, y, active_pixels, game_state, menu_selection,
           player_x, player_height, obs_x, obs_y, obs_w, obs_h, obs_valid,
           hit_pulse, t_start, t_howto, t_hud, i_white, i_green, i_red,
    input  VGA_R, VGA_G, VGA_B, active_out, collision
  );

  modport slave (
    input  x, y, active_pixels, game_state, menu_selection,
           player_x, player_height, obs_x, obs_y, obs_w, obs_h, obs_valid,
           hit_pulse, t_start, t_howto, t_hud, i_white, i_green, i_red,
    output VGA_R, VGA_G, VGA_B, active_out, collision
  );
endinterface

// File: rtl/vga_scene_renderer.sv
// Two-stage pixel renderer: frame-synchronous object snapshot, hit tests, colour
// priority mux, player hit-flash and per-frame player/obstacle collision report.
module vga_scene_renderer #(
  parameter int unsigned NUM_OBS         = 4,
  parameter int unsigned COLOR_W         = 8,
  parameter int unsigned BOX_WIDTH       = 30,
  parameter int unsigned BOX_BASE_HEIGHT = 30,
  parameter int unsigned BOX_Y_START     = 345,
  parameter int unsigned BANK_X_START    = 50,
  parameter int unsigned BANK_WIDTH      = 60,
  parameter int unsigned FLASH_FRAMES    = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  vga_scene_renderer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_START   = 2'b00,
    ST_PLAYING = 2'b01,
    ST_INSTR   = 2'b10,
    ST_OVER    = 2'b11
  } game_state_e;

  localparam logic [10:0] P_WIDTH   = 11'(BOX_WIDTH);
  localparam logic [10:0] GROUND    = 11'(BOX_Y_START);
  localparam logic [10:0] BANK_L    = 11'(BANK_X_START);
  localparam logic [10:0] BANK_R    = 11'(BANK_X_START + BANK_WIDTH);
  localparam logic [10:0] BANK_TOP  = 11'(BOX_Y_START - BOX_BASE_HEIGHT + 1);
  localparam logic [7:0]  FLASH_INI = 8'(FLASH_FRAMES);

  localparam logic [COLOR_W-1:0] FULL = '1;
  localparam logic [COLOR_W-1:0] NONE = '0;
  // Alternating 0101... from the MSB down, for any channel width.
  localparam logic [COLOR_W-1:0] DIM  = COLOR_W'({(COLOR_W + 1) / 2 {2'b01}} >> (COLOR_W % 2));
  localparam logic [COLOR_W-1:0] HALF = COLOR_W'(1) << (COLOR_W - 1);

  // Snapshot of object state, reloaded on every frame_start
  game_state_e           snap_state;
  logic                  snap_menu;
  logic                  snap_ok;
  logic [9:0]            snap_px;
  logic [9:0]            snap_ph;
  logic [10*NUM_OBS-1:0] snap_ox;
  logic [10*NUM_OBS-1:0] snap_oy;
  logic [10*NUM_OBS-1:0] snap_ow;
  logic [10*NUM_OBS-1:0] snap_oh;
  logic [NUM_OBS-1:0]    snap_valid;

  logic [7:0] flash_cnt;
  logic       ovl;

  // Stage-1 registers
  game_state_e s1_state;
  logic s1_menu, s1_flash, s1_act, s1_gate;
  logic s1_player, s1_obs, s1_bank, s1_deadx;
  logic s1_t_start, s1_t_howto, s1_t_hud, s1_i_white, s1_i_green, s1_i_red;

  // Combinational hit tests
  logic        frame_start;
  logic [10:0] x11, y11, p_left, p_top;
  logic [10:0] ox, oy, ow, oh;
  logic        hit_player, hit_obs, hit_bank, hit_deadx;

  always_comb begin
    frame_start = (bus.x == '0) && (bus.y == '0);
    x11    = {1'b0, bus.x};
    y11    = {1'b0, bus.y};
    p_left = {1'b0, snap_px};
    if ({1'b0, snap_ph} > GROUND + 11'd1) p_top = '0;
    else                                  p_top = GROUND + 11'd1 - {1'b0, snap_ph};

    hit_player = (snap_ph != '0) &&
                 (x11 >= p_left) && (x11 < p_left + P_WIDTH) &&
                 (y11 >= p_top)  && (y11 <= GROUND);

    ox = '0;
    oy = '0;
    ow = '0;
    oh = '0;
    hit_obs = 1'b0;
    // A zero width or height collapses the interval, so it never hits.
    for (int unsigned i = 0; i < NUM_OBS; i++) begin
      ox = {1'b0, snap_ox[10*i +: 10]};
      oy = {1'b0, snap_oy[10*i +: 10]};
      ow = {1'b0, snap_ow[10*i +: 10]};
      oh = {1'b0, snap_oh[10*i +: 10]};
      if (snap_valid[i] && (x11 >= ox) && (x11 < ox + ow) &&
          (y11 >= oy) && (y11 < oy + oh))
        hit_obs = 1'b1;
    end

    hit_bank  = (x11 >= BANK_L) && (x11 < BANK_R) && (y11 >= BANK_TOP) && (y11 <= GROUND);
    hit_deadx = (x11 == y11 + 11'd80) || (x11 == 11'd720 - y11);
  end

  // Stage-2 colour mux
  logic [COLOR_W-1:0] r_n, g_n, b_n;
  logic               ovl_hit;

  always_comb begin
    r_n = NONE;
    g_n = NONE;
    b_n = NONE;
    if (s1_gate) begin
      unique case (s1_state)
        ST_START: begin
          if (s1_t_start) begin
            r_n = s1_menu ? DIM : FULL;
            g_n = r_n;
            b_n = r_n;
          end else if (s1_t_howto) begin
            r_n = s1_menu ? FULL : DIM;
            g_n = r_n;
            b_n = r_n;
          end else begin
            b_n = HALF;
          end
        end
        ST_INSTR: begin
          if (s1_i_green)      g_n = FULL;
          else if (s1_i_red)   r_n = FULL;
          else if (s1_i_white) begin
            r_n = FULL;
            g_n = FULL;
            b_n = FULL;
          end
        end
        ST_OVER: begin
          if (!s1_deadx) r_n = FULL;
        end
        ST_PLAYING: begin
          if (s1_t_hud) begin
            r_n = NONE;
          end else if (s1_obs) begin
            r_n = FULL;
          end else if (s1_player) begin
            if (s1_flash) r_n = FULL;
            else          b_n = FULL;
          end else if (s1_bank) begin
            g_n = FULL;
          end else begin
            r_n = FULL;
            g_n = FULL;
            b_n = FULL;
          end
        end
        default: r_n = NONE;
      endcase
    end
    ovl_hit = s1_player && s1_obs && s1_gate && (s1_state == ST_PLAYING);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_state     <= ST_START;
      snap_menu      <= 1'b0;
      snap_ok        <= 1'b0;
      snap_px        <= '0;
      snap_ph        <= '0;
      snap_ox        <= '0;
      snap_oy        <= '0;
      snap_ow        <= '0;
      snap_oh        <= '0;
      snap_valid     <= '0;
      flash_cnt      <= '0;
      ovl            <= 1'b0;
      s1_state       <= ST_START;
      s1_menu        <= 1'b0;
      s1_flash       <= 1'b0;
      s1_act         <= 1'b0;
      s1_gate        <= 1'b0;
      s1_player      <= 1'b0;
      s1_obs         <= 1'b0;
      s1_bank        <= 1'b0;
      s1_deadx       <= 1'b0;
      s1_t_start     <= 1'b0;
      s1_t_howto     <= 1'b0;
      s1_t_hud       <= 1'b0;
      s1_i_white     <= 1'b0;
      s1_i_green     <= 1'b0;
      s1_i_red       <= 1'b0;
      bus.VGA_R      <= '0;
      bus.VGA_G      <= '0;
      bus.VGA_B      <= '0;
      bus.active_out <= 1'b0;
      bus.collision  <= 1'b0;
    end else begin
      if (frame_start) begin
        snap_state <= game_state_e'(bus.game_state);
        snap_menu  <= bus.menu_selection;
        snap_ok    <= 1'b1;
        snap_px    <= bus.player_x;
        snap_ph    <= bus.player_height;
        snap_ox    <= bus.obs_x;
        snap_oy    <= bus.obs_y;
        snap_ow    <= bus.obs_w;
        snap_oh    <= bus.obs_h;
        snap_valid <= bus.obs_valid;
      end

      if (snap_state != ST_PLAYING)               flash_cnt <= '0;
      else if (bus.hit_pulse)                     flash_cnt <= FLASH_INI;
      else if (frame_start && flash_cnt != '0)    flash_cnt <= flash_cnt - 8'd1;

      // Per-frame context travels with the pixel so the (0,0) snapshot reload
      // cannot change the colour of a pixel already in flight.
      s1_state   <= snap_state;
      s1_menu    <= snap_menu;
      s1_flash   <= (flash_cnt != '0) && flash_cnt[2];
      s1_act     <= bus.active_pixels;
      s1_gate    <= bus.active_pixels && snap_ok;
      s1_player  <= hit_player;
      s1_obs     <= hit_obs;
      s1_bank    <= hit_bank;
      s1_deadx   <= hit_deadx;
      s1_t_start <= bus.t_start;
      s1_t_howto <= bus.t_howto;
      s1_t_hud   <= bus.t_hud;
      s1_i_white <= bus.i_white;
      s1_i_green <= bus.i_green;
      s1_i_red   <= bus.i_red;

      bus.VGA_R      <= r_n;
      bus.VGA_G      <= g_n;
      bus.VGA_B      <= b_n;
      bus.active_out <= s1_act;

      if (frame_start) begin
        bus.collision <= ovl;
        ovl           <= ovl_hit;
      end else begin
        bus.collision <= 1'b0;
        ovl           <= ovl | ovl_hit;
      end
    end
  end

endmodule

// File: tb/tb_vga_scene_renderer.sv
// Randomised scoreboard bench for vga_scene_renderer with a behavioural scene model.
module tb_vga_scene_renderer;

  localparam int NOBS = 4;

  localparam logic [23:0] C_BLACK = 24'h000000;
  localparam logic [23:0] C_WHITE = 24'hFFFFFF;
  localparam logic [23:0] C_GREY  = 24'h555555;
  localparam logic [23:0] C_RED   = 24'hFF0000;
  localparam logic [23:0] C_GREEN = 24'h00FF00;
  localparam logic [23:0] C_BLUE  = 24'h0000FF;
  localparam logic [23:0] C_BG    = 24'h000080;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_scene_renderer_if #(.NUM_OBS(NOBS), .COLOR_W(8)) bus ();

  vga_scene_renderer #(
    .NUM_OBS(NOBS), .COLOR_W(8), .BOX_WIDTH(30), .BOX_BASE_HEIGHT(30),
    .BOX_Y_START(345), .BANK_X_START(50), .BANK_WIDTH(60), .FLASH_FRAMES(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    int          due;
    logic [23:0] rgb;
    logic        act;
  } pix_t;

  typedef struct packed {
    int   due;
    logic col;
  } col_t;

  pix_t pix_q[$];
  col_t col_q[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Values to present with the next pixel
  int d_gs, d_px, d_ph;
  bit d_menu, d_act, d_ts, d_th, d_hud, d_iw, d_ig, d_ir, hp_req;
  int d_ox[NOBS], d_oy[NOBS], d_ow[NOBS], d_oh[NOBS];
  bit d_v[NOBS];

  // Model state: what the renderer should currently believe about the scene
  int m_gs, m_px, m_ph, m_cnt;
  bit m_menu, m_ok, m_ovl, m_pend;
  int m_ox[NOBS], m_oy[NOBS], m_ow[NOBS], m_oh[NOBS];
  bit m_v[NOBS];

  function automatic void model_pixel(input int x, input int y,
                                      output logic [23:0] rgb, output bit hit);
    bit pl, ob, bk, dx, fl;
    int top;
    top = (m_ph > 346) ? 0 : 346 - m_ph;
    pl  = (m_ph != 0) && x >= m_px && x < m_px + 30 && y >= top && y <= 345;
    ob  = 0;
    for (int i = 0; i < NOBS; i++)
      if (m_v[i] && x >= m_ox[i] && x < m_ox[i] + m_ow[i] &&
          y >= m_oy[i] && y < m_oy[i] + m_oh[i]) ob = 1;
    bk  = x >= 50 && x < 110 && y >= 316 && y <= 345;
    dx  = (x == y + 80) || (x == 720 - y);
    fl  = (m_cnt % 8) >= 4;
    hit = (m_gs == 1) && d_act && pl && ob;
    rgb = C_BLACK;
    if (d_act && m_ok) begin
      case (m_gs)
        0: if (d_ts)      rgb = m_menu ? C_GREY : C_WHITE;
           else if (d_th) rgb = m_menu ? C_WHITE : C_GREY;
           else           rgb = C_BG;
        2: if (d_ig)      rgb = C_GREEN;
           else if (d_ir) rgb = C_RED;
           else if (d_iw) rgb = C_WHITE;
        3: rgb = dx ? C_BLACK : C_RED;
        default:
           if (d_hud)     rgb = C_BLACK;
           else if (ob)   rgb = C_RED;
           else if (pl)   rgb = fl ? C_RED : C_BLUE;
           else if (bk)   rgb = C_GREEN;
           else           rgb = C_WHITE;
      endcase
    end
  endfunction

  task automatic issue(input int px, input int py);
    logic [23:0] rgb;
    bit hit, fs, ecol;
    @(posedge clk);
    #1;
    bus.x = 10'(px);
    bus.y = 10'(py);
    bus.active_pixels = d_act;
    bus.game_state = 2'(d_gs);
    bus.menu_selection = d_menu;
    bus.player_x = 10'(d_px);
    bus.player_height = 10'(d_ph);
    for (int i = 0; i < NOBS; i++) begin
      bus.obs_x[10*i +: 10] = 10'(d_ox[i]);
      bus.obs_y[10*i +: 10] = 10'(d_oy[i]);
      bus.obs_w[10*i +: 10] = 10'(d_ow[i]);
      bus.obs_h[10*i +: 10] = 10'(d_oh[i]);
      bus.obs_valid[i] = d_v[i];
    end
    bus.hit_pulse = hp_req;
    bus.t_start = d_ts;
    bus.t_howto = d_th;
    bus.t_hud = d_hud;
    bus.i_white = d_iw;
    bus.i_green = d_ig;
    bus.i_red = d_ir;

    fs = (px == 0) && (py == 0);
    model_pixel(px, py, rgb, hit);
    pix_q.push_back('{due: cyc + 2, rgb: rgb, act: d_act});

    // Overlap of the previous pixel lands in the frame that starts now.
    if (fs) begin
      ecol = m_ovl;
      m_ovl = m_pend;
    end else begin
      ecol = 1'b0;
      m_ovl = m_ovl | m_pend;
    end
    col_q.push_back('{due: cyc + 1, col: ecol});
    m_pend = hit;

    if (m_gs != 1)             m_cnt = 0;
    else if (hp_req)           m_cnt = 32;
    else if (fs && m_cnt != 0) m_cnt = m_cnt - 1;
    hp_req = 0;

    if (fs) begin
      m_ok = 1; m_gs = d_gs; m_menu = d_menu; m_px = d_px; m_ph = d_ph;
      for (int i = 0; i < NOBS; i++) begin
        m_ox[i] = d_ox[i]; m_oy[i] = d_oy[i];
        m_ow[i] = d_ow[i]; m_oh[i] = d_oh[i]; m_v[i] = d_v[i];
      end
    end
  endtask

  always @(negedge clk) begin
    pix_t pe;
    col_t ce;
    if (pix_q.size() != 0 && pix_q[0].due == cyc) begin
      pe = pix_q.pop_front();
      n_tests++;
      if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== pe.rgb || bus.active_out !== pe.act) begin
        n_fail++;
        $display("FAIL pixel cyc=%0d: got rgb=%06h act=%b, expected rgb=%06h act=%b",
                 cyc, {bus.VGA_R, bus.VGA_G, bus.VGA_B}, bus.active_out, pe.rgb, pe.act);
      end
    end
    if (col_q.size() != 0 && col_q[0].due == cyc) begin
      ce = col_q.pop_front();
      n_tests++;
      if (bus.collision !== ce.col) begin
        n_fail++;
        $display("FAIL collision cyc=%0d: got %b, expected %b", cyc, bus.collision, ce.col);
      end
    end
  end

  task automatic clear_scene();
    d_gs = 1; d_menu = 0; d_px = 100; d_ph = 30; d_act = 1;
    d_ts = 0; d_th = 0; d_hud = 0; d_iw = 0; d_ig = 0; d_ir = 0;
    for (int i = 0; i < NOBS; i++) begin
      d_ox[i] = 0; d_oy[i] = 0; d_ow[i] = 0; d_oh[i] = 0; d_v[i] = 0;
    end
  endtask

  task automatic random_scene();
    d_gs = ($urandom_range(0, 2) != 0) ? 1 : int'($urandom_range(0, 3));
    d_menu = 1'($urandom_range(0, 1));
    d_px = $urandom_range(0, 1023);
    d_ph = $urandom_range(0, 420);
    for (int i = 0; i < NOBS; i++) begin
      d_ox[i] = $urandom_range(0, 1023); d_oy[i] = $urandom_range(0, 1023);
      d_ow[i] = $urandom_range(0, 63);   d_oh[i] = $urandom_range(0, 63);
      d_v[i]  = 1'($urandom_range(0, 1));
    end
    if ($urandom_range(0, 1) == 1) begin
      d_ox[0] = (d_px + $urandom_range(0, 20)) % 1024;
      d_oy[0] = $urandom_range(300, 345);
      d_v[0]  = 1;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx, ry, sel;
    hp_req = 0;
    m_gs = 0; m_px = 0; m_ph = 0; m_cnt = 0; m_menu = 0; m_ok = 0; m_ovl = 0; m_pend = 0;
    for (int i = 0; i < NOBS; i++) begin
      m_ox[i] = 0; m_oy[i] = 0; m_ow[i] = 0; m_oh[i] = 0; m_v[i] = 0;
    end
    clear_scene();
    d_act = 0;
    bus.x = 10'd5; bus.y = 10'd5; bus.active_pixels = 1'b0; bus.game_state = 2'd0;
    bus.menu_selection = 1'b0; bus.player_x = '0; bus.player_height = '0;
    bus.obs_x = '0; bus.obs_y = '0; bus.obs_w = '0; bus.obs_h = '0; bus.obs_valid = '0;
    bus.hit_pulse = 1'b0; bus.t_start = 1'b0; bus.t_howto = 1'b0; bus.t_hud = 1'b0;
    bus.i_white = 1'b0; bus.i_green = 1'b0; bus.i_red = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h0 || bus.active_out !== 1'b0 ||
        bus.collision !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got rgb=%06h act=%b col=%b, expected all zero",
               {bus.VGA_R, bus.VGA_G, bus.VGA_B}, bus.active_out, bus.collision);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic playing scene; pixels before the first (0,0) must stay black
    clear_scene();
    d_ox[0] = 200; d_oy[0] = 300; d_ow[0] = 20; d_oh[0] = 20; d_v[0] = 1;
    d_ox[3] = 200; d_oy[3] = 300; d_ow[3] = 20; d_oh[3] = 20; d_v[3] = 0;
    issue(110, 330); issue(60, 345);
    issue(0, 0);
    issue(110, 330); issue(110, 314); issue(60, 345); issue(205, 305); issue(220, 305);
    d_v[0] = 0;
    issue(205, 305); issue(0, 0); issue(205, 305);

    // Overlap on the player rectangle, then a frame without it
    d_ox[1] = 105; d_oy[1] = 320; d_ow[1] = 10; d_oh[1] = 10; d_v[1] = 1;
    issue(0, 0); issue(110, 325); issue(110, 325); issue(300, 10);
    d_v[1] = 0;
    issue(0, 0); issue(110, 325); issue(0, 0); issue(5, 5);

    // Hit flash across 40 frames
    hp_req = 1;
    issue(110, 330);
    for (int f = 0; f < 40; f++) begin
      issue(0, 0); issue(110, 330); issue(120, 340);
    end

    // START menu, hit_pulse ignored there
    d_gs = 0; d_menu = 1;
    issue(0, 0);
    d_ts = 1; issue(400, 200);
    d_ts = 0; d_th = 1; issue(400, 220);
    d_th = 0; issue(400, 240);
    hp_req = 1; issue(400, 260);
    d_gs = 1; issue(0, 0); issue(110, 330);

    // Instructions and game over
    d_gs = 2; issue(0, 0);
    d_ig = 1; issue(10, 10); d_ig = 0; d_ir = 1; issue(10, 10);
    d_ir = 0; d_iw = 1; issue(10, 10); d_iw = 0; issue(10, 10);
    d_gs = 3; issue(0, 0); issue(180, 100); issue(181, 100); issue(620, 100);

    // Height clamp and right-edge obstacle
    d_gs = 1; d_ph = 400;
    d_ox[2] = 1020; d_oy[2] = 500; d_ow[2] = 10; d_oh[2] = 10; d_v[2] = 1;
    issue(0, 0); issue(110, 0); issue(110, 1023); issue(1023, 505); issue(0, 505);

    // Randomised scenes and scan positions
    for (int k = 0; k < 3000; k++) begin
      d_act = ($urandom_range(0, 9) != 0);
      d_ts = ($urandom_range(0, 3) == 0); d_th = ($urandom_range(0, 3) == 0);
      d_hud = ($urandom_range(0, 7) == 0);
      d_iw = ($urandom_range(0, 2) == 0); d_ig = ($urandom_range(0, 2) == 0);
      d_ir = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) hp_req = 1;
      if ($urandom_range(0, 59) == 0) begin
        random_scene();
        issue(0, 0);
      end else begin
        sel = $urandom_range(0, 2);
        if (sel == 0) begin
          rx = $urandom_range(0, 1023); ry = $urandom_range(0, 1023);
        end else if (sel == 1) begin
          rx = (d_px + $urandom_range(0, 45) + 1019) % 1024; ry = $urandom_range(0, 350);
        end else begin
          rx = (d_ox[0] + $urandom_range(0, 70) + 1019) % 1024;
          ry = (d_oy[0] + $urandom_range(0, 70) + 1019) % 1024;
        end
        if (rx == 0 && ry == 0) rx = 1;
        issue(rx, ry);
      end
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (pix_q.size() != 0 || col_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pixel and %0d collision expectations left, expected 0",
               pix_q.size(), col_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scene_renderer.md
# vga_scene_renderer

Registered, parametrised pixel renderer for the game display path: takes the VGA scan position plus game-object state and produces the RGB colour for each pixel. It supports NUM_OBS independent obstacles, frame-synchronous snapshotting of all object state (no tearing), a two-stage pipeline, a hit-flash effect on the player, and per-pixel player/obstacle collision reporting. It sits between the VGA timing generator / text layer and the DAC pins, in place of the purely combinational colour mux.

## Interface
- NUM_OBS, 4: obstacle channel count (1–8).
- COLOR_W, 8: bits per colour channel.
- BOX_WIDTH, 30: player width in pixels.
- BOX_BASE_HEIGHT, 30: bank height in pixels.
- BOX_Y_START, 345: ground row; player and bank bottom edge, inclusive.
- BANK_X_START, 50: bank left edge.
- BANK_WIDTH, 60: bank width.
- FLASH_FRAMES, 32: frame count of the hit-flash effect, 1–255.
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- x, y  in  10 each  scan position, including blanking.
- active_pixels  in  1  visible-region flag.
- game_state  in  2  00 START, 01 PLAYING, 10 INSTRUCTIONS, 11 GAME_OVER.
- menu_selection  in  1  0 = Start selected, 1 = How-To selected.
- player_x, player_height  in  10 each  player left edge, player height.
- obs_x, obs_y, obs_w, obs_h  in  10*NUM_OBS each  packed obstacle geometry; channel i is bits [10i+9:10i].
- obs_valid  in  NUM_OBS  per-channel enable.
- hit_pulse  in  1  one-cycle player-damage event.
- t_start, t_howto, t_hud, i_white, i_green, i_red  in  1 each  text masks for the current x,y.
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  registered pixel colour.
- active_out  out  1  active_pixels delayed to align with the colour.
- collision  out  1  one-cycle pulse: the previous frame had at least one player/obstacle overlap pixel.

## Operation
- frame_start = (x==0 && y==0). On that clock edge, the snapshot registers load game_state, menu_selection, player_x, player_height, and all obs_* / obs_valid. Every hit test uses only the snapshot values. Pixel (0,0) is rendered with the previous snapshot.
- Stage 1 registers the hit flags, computed on x, y and the snapshot:
  - Player: x ∈ [player_x, player_x+BOX_WIDTH) and y ∈ [top, BOX_Y_START].
    - top = BOX_Y_START − player_height + 1.
    - player_height==0 means no player.
    - player_height > BOX_Y_START+1 clamps top to 0.
  - Obstacle i: obs_valid[i] and x ∈ [obs_x, obs_x+obs_w) and y ∈ [obs_y, obs_y+obs_h). A width or height of 0 means no hit. is_obs = OR over all channels.
  - Bank: x ∈ [BANK_X_START, BANK_X_START+BANK_WIDTH) and y ∈ [BOX_Y_START−BOX_BASE_HEIGHT+1, BOX_Y_START].
  - Dead-X: x == y+80 or x == 720−y.
  - All sums and differences use 11-bit arithmetic, so edges near 1023 do not wrap.
  - The text masks and active_pixels are registered alongside the hit flags.
- Stage 2 registers the colour. Full = all ones, DIM = 0x55 scaled to COLOR_W (top bits 01010101…). Priority is top to bottom:
  - active=0: black.
  - START: t_start → white if menu_selection==0, else DIM. t_howto → white if menu_selection==1, else DIM. Otherwise background (0,0,half-scale blue, i.e. MSB only).
  - INSTRUCTIONS: i_green → green. i_red → red. i_white → white. Otherwise black.
  - GAME_OVER: dead-X → black. Otherwise red.
  - PLAYING: t_hud → black. Then is_obs → red. Then player → blue, or red while flashing. Then bank → green. Otherwise white.
- Flash counter (8 bits):
  - hit_pulse loads FLASH_FRAMES; it is edge-independent and takes priority over the decrement.
  - Otherwise it decrements by 1 on each frame_start while nonzero.
  - flashing = (cnt≠0) and cnt[2]. The player toggles blue/red every 4 frames.
  - hit_pulse is ignored unless the snapshot game_state is PLAYING; the counter clears on any non-PLAYING snapshot.
- Collision:
  - Sticky flag ovl sets when a stage-1 pixel has player AND is_obs AND active, in PLAYING.
  - At frame_start, collision <= ovl and ovl clears. If an overlap and frame_start occur in the same cycle, the overlap counts toward the new frame.

## Timing
- Latency: 2 clocks. Pixel (x,y) presented at cycle n appears on VGA_*/active_out at the edge ending cycle n+2.
- Throughput: 1 pixel per clock, no stalls.
- Reset (rst_n=0 at an edge):
  - VGA_R/G/B = 0, active_out = 0, collision = 0.
  - All pipeline flags = 0, snapshots = 0 (state START), flash counter = 0, ovl = 0.
  - The first valid colour appears 2 clocks after rst_n rises.
  - Reset mid-frame: the pipeline outputs black until the first frame_start reloads the snapshot.
- collision is high for exactly the one cycle after a frame_start edge.

## Test plan
- Reset, then scan with PLAYING, player_x=100, height=30 → pixel (110,330) is blue 2 clocks later; (110,314) is white; (60,345) is green.
- Obstacles: ch0 (200,300,20,20) valid, ch3 (200,300,20,20) valid=0 → (205,305) red, (220,305) white. Clear valid on ch0 mid-frame → still red until the next (0,0).
- Overlap: obstacle at the player's rectangle → collision pulses once, 1 cycle, after the next frame_start. Without overlap, collision stays 0.
- hit_pulse with FLASH_FRAMES=32 → the player is red during frames with cnt[2]=1 and blue after 32 frames. A hit_pulse in START has no effect.
- START, menu_selection=1 → a t_start pixel is 0x55 grey, a t_howto pixel is white, the background is (0,0,0x80). GAME_OVER: (180,100) black, (181,100) red.
- Edge case: player_height=400 → top clamps to 0, no wrap. obs_x=1020, obs_w=10 → x=1023 hits and x=0 does not.
